// File: rtl/clkdiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_ctrl_if
// Brief    : Reconfiguration request port of the divided-clock controller.
// Revision : 1.0 - initial release
// ============================================================================
interface clkdiv_ctrl_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 cfg_sel;
  logic [CNT_WIDTH-1:0] cfg_div;
  logic                 cfg_en;
  logic                 busy;
  logic                 err;

  modport master (
    output cfg_valid, cfg_sel, cfg_div, cfg_en,
    input  cfg_ready, busy, err
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_div, cfg_en,
    output cfg_ready, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_ctrl
// Brief    : Two-channel clock divider with glitch-free runtime reconfiguration.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_ctrl #(
  parameter int CNT_WIDTH = 8,
  parameter int DIV1_INIT = 4,
  parameter int DIV2_INIT = 10
) (
  input  wire logic     clkin,
  input  wire logic     reset_n,
  clkdiv_ctrl_if.slave  cfg,
  output logic          clkout1,
  output logic          clkout2
);

  localparam logic [CNT_WIDTH-1:0] c_half1_init = CNT_WIDTH'(DIV1_INIT / 2);
  localparam logic [CNT_WIDTH-1:0] c_half2_init = CNT_WIDTH'(DIV2_INIT / 2);
  localparam logic [CNT_WIDTH-1:0] c_one        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_two        = CNT_WIDTH'(2);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_err;
  logic                 r_req_sel;
  logic                 r_req_en;
  logic [CNT_WIDTH-1:0] r_req_half;

  logic [CNT_WIDTH-1:0] r_half [2];
  logic [CNT_WIDTH-1:0] r_cnt  [2];
  logic [1:0]           r_en;
  logic [1:0]           r_clk;

  logic [1:0]           w_wrap;
  logic                 w_apply;
  logic                 w_bad;

  always_comb begin
    w_wrap = '0;
    for (int i = 0; i < 2; i++) begin
      w_wrap[i] = (r_cnt[i] == (r_half[i] - c_one));
    end
  end

  // Enabled target: apply on the edge that would raise the output, so the
  // low phase in progress always completes with the old ratio.
  assign w_apply = (r_state == ST_WAIT) &&
                   (!r_en[r_req_sel] || (!r_clk[r_req_sel] && w_wrap[r_req_sel]));

  assign w_bad = cfg.cfg_en && (cfg.cfg_div[0] || (cfg.cfg_div < c_two));

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_req_sel  <= 1'b0;
      r_req_en   <= 1'b0;
      r_req_half <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg.cfg_valid) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_req_sel  <= cfg.cfg_sel;
              r_req_en   <= cfg.cfg_en;
              r_req_half <= cfg.cfg_div >> 1;
              r_state    <= ST_WAIT;
              r_ready    <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (w_apply) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_half[0] <= c_half1_init;
      r_half[1] <= c_half2_init;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
      r_en  <= 2'b11;
      r_clk <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_apply && (r_req_sel == 1'(i))) begin
          if (r_req_en) begin
            r_half[i] <= r_req_half;
          end
          r_cnt[i] <= '0;
          r_clk[i] <= r_req_en;
          r_en[i]  <= r_req_en;
        end else if (r_en[i]) begin
          if (w_wrap[i]) begin
            r_cnt[i] <= '0;
            r_clk[i] <= ~r_clk[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + c_one;
          end
        end else begin
          r_cnt[i] <= '0;
          r_clk[i] <= 1'b0;
        end
      end
    end
  end

  assign cfg.cfg_ready = r_ready;
  assign cfg.busy      = r_busy;
  assign cfg.err       = r_err;
  assign clkout1       = r_clk[0];
  assign clkout2       = r_clk[1];

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv_ctrl
// Brief    : Scoreboard bench for clkdiv_ctrl reconfiguration and divided clocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_ctrl;
  localparam int CW = 8;

  logic clkin   = 1'b0;
  logic reset_n = 1'b1;
  logic clkout1;
  logic clkout2;

  clkdiv_ctrl_if #(.CNT_WIDTH(CW)) cfg_if ();

  clkdiv_ctrl #(
    .CNT_WIDTH(CW),
    .DIV1_INIT(4),
    .DIV2_INIT(10)
  ) dut (
    .clkin   (clkin),
    .reset_n (reset_n),
    .cfg     (cfg_if.slave),
    .clkout1 (clkout1),
    .clkout2 (clkout2)
  );

  always #10 clkin = ~clkin;

  typedef struct {
    bit rej;
    bit sel;
    bit en;
    bit old_en;
    int new_half;
    int old_ratio;
    int tcyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc;
  int         n_apply  = 0;
  int         n_rej    = 0;
  int         last_apply = 0;
  int         active_meas = 0;
  int         cur_half [2];
  bit         cur_en   [2];
  bit         prev_ready;
  bit         err_follow;
  logic [1:0] prev_cko;
  int         h;
  int         l;
  int         lowc;

  always @(posedge clkin or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic cko(input int ch);
    return (ch != 0) ? clkout2 : clkout1;
  endfunction

  task automatic send(input bit sel, input int div, input bit en);
    int waited = 0;
    exp_t x;
    #1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = sel;
    cfg_if.cfg_div   = CW'(div);
    cfg_if.cfg_en    = en;
    while (!cfg_if.cfg_ready && waited < 200) begin
      @(negedge clkin);
      #1;
      waited++;
    end
    if (!cfg_if.cfg_ready) begin
      check_eq("send_ready_timeout", 0, 1);
      cfg_if.cfg_valid = 1'b0;
      return;
    end
    x.rej       = en && ((div % 2) == 1 || div < 2);
    x.sel       = sel;
    x.en        = en;
    x.old_en    = cur_en[sel];
    x.new_half  = div / 2;
    x.old_ratio = 2 * cur_half[sel];
    x.tcyc      = cyc + 1;
    sb.push_back(x);
    @(posedge clkin);
    #1;
  endtask

  task automatic wait_rise(input int ch);
    int n = 0;
    @(negedge clkin);
    while (cko(ch) && n < 600) begin @(negedge clkin); n++; end
    while (!cko(ch) && n < 600) begin @(negedge clkin); n++; end
    check_eq("rise_seen", int'(n < 600), 1);
  endtask

  task automatic count_high(input int ch, output int hi);
    hi = 0;
    while (cko(ch) && hi < 600) begin hi++; @(negedge clkin); end
  endtask

  task automatic count_low(input int ch, output int lo);
    lo = 0;
    while (!cko(ch) && lo < 600) begin lo++; @(negedge clkin); end
  endtask

  task automatic phases(input int ch, output int hi, output int lo);
    wait_rise(ch);
    count_high(ch, hi);
    count_low(ch, lo);
  endtask

  task automatic meas_after_apply(input int ch, input int half);
    int hi;
    int lo;
    count_high(ch, hi);
    count_low(ch, lo);
    check_eq($sformatf("new_high_ch%0d", ch + 1), hi, half);
    check_eq($sformatf("new_low_ch%0d", ch + 1), lo, half);
    active_meas--;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!cfg_if.cfg_ready || sb.size() != 0 || active_meas != 0) && n < 2000) begin
      @(negedge clkin);
      n++;
    end
    check_eq("idle_reached", int'(n < 2000), 1);
  endtask

  // Response side of the scoreboard: err pulses and ready re-assertions.
  initial begin
    prev_ready = 1'b1;
    err_follow = 1'b0;
    prev_cko   = 2'b00;
    forever begin
      @(negedge clkin);
      if (!reset_n) begin
        prev_ready = 1'b1;
        err_follow = 1'b0;
        prev_cko   = 2'b00;
      end else begin
        if (err_follow) begin
          check_eq("err_one_cycle", int'(cfg_if.err), 0);
          err_follow = 1'b0;
        end
        if (cfg_if.err) begin
          err_follow = 1'b1;
          n_rej++;
          if (sb.size() == 0) begin
            check_eq("sb_underflow_err", 0, 1);
          end else begin
            e = sb.pop_front();
            check_eq("rej_expected", int'(e.rej), 1);
            check_eq("err_latency", cyc - e.tcyc, 0);
            check_eq("ready_on_err", int'(cfg_if.cfg_ready), 1);
          end
        end
        if (cfg_if.cfg_ready && !prev_ready) begin
          n_apply++;
          if (sb.size() == 0) begin
            check_eq("sb_underflow_apply", 0, 1);
          end else begin
            e = sb.pop_front();
            check_eq("apply_not_rej", int'(e.rej), 0);
            check_eq("busy_low_after_apply", int'(cfg_if.busy), 0);
            check_eq("xfer_after_prev_apply", int'(e.tcyc > last_apply), 1);
            if (!e.old_en) check_eq("apply_lat_disabled", cyc - e.tcyc, 1);
            else           check_eq("apply_lat_range",
                                    int'((cyc - e.tcyc) >= 1 && (cyc - e.tcyc) <= e.old_ratio), 1);
            check_eq("apply_out_level", int'(cko(int'(e.sel))), int'(e.en));
            if (e.old_en) check_eq("apply_prev_low", int'(prev_cko[e.sel]), 0);
            if (e.en) begin
              cur_half[e.sel] = e.new_half;
              active_meas++;
              fork
                meas_after_apply(int'(e.sel), e.new_half);
              join_none
            end
            cur_en[e.sel] = e.en;
            last_apply = cyc;
          end
        end
        prev_ready = cfg_if.cfg_ready;
        prev_cko   = {clkout2, clkout1};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel   = 1'b0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_en    = 1'b0;
    cur_half = '{2, 5};
    cur_en   = '{1'b1, 1'b1};

    // Reset defaults
    #1 reset_n = 1'b0;
    #5;
    check_eq("rst_clkout1", int'(clkout1), 0);
    check_eq("rst_clkout2", int'(clkout2), 0);
    check_eq("rst_busy", int'(cfg_if.busy), 0);
    check_eq("rst_err", int'(cfg_if.err), 0);
    #34 reset_n = 1'b1;
    wait_rise(0);
    check_eq("first_rise_edge", cyc, 2);
    check_eq("ready_after_rst", int'(cfg_if.cfg_ready), 1);
    phases(0, h, l);
    check_eq("def_high_ch1", h, 2);
    check_eq("def_low_ch1", l, 2);
    phases(1, h, l);
    check_eq("def_high_ch2", h, 5);
    check_eq("def_low_ch2", l, 5);

    // Channel 1 to ratio 6, requested during its high phase
    wait_rise(0);
    send(1'b0, 6, 1'b1);
    cfg_if.cfg_valid = 1'b0;
    phases(1, h, l);
    check_eq("ch2_undisturbed_high", h, 5);
    check_eq("ch2_undisturbed_low", l, 5);
    wait_idle();

    // Odd and too-small ratios rejected
    send(1'b0, 5, 1'b1);
    cfg_if.cfg_valid = 1'b0;
    repeat (3) @(negedge clkin);
    send(1'b0, 0, 1'b1);
    cfg_if.cfg_valid = 1'b0;
    wait_idle();
    phases(0, h, l);
    check_eq("after_rej_high_ch1", h, 3);
    check_eq("after_rej_low_ch1", l, 3);
    phases(1, h, l);
    check_eq("after_rej_high_ch2", h, 5);
    check_eq("after_rej_low_ch2", l, 5);

    // Disable channel 2 mid high phase, then re-enable at ratio 2
    wait_rise(1);
    fork
      begin
        send(1'b1, 7, 1'b0);
        cfg_if.cfg_valid = 1'b0;
      end
      count_high(1, h);
    join
    check_eq("disable_full_high", h, 5);
    wait_idle();
    lowc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkin);
      if (!clkout2) lowc++;
    end
    check_eq("disabled_held_low", lowc, 30);
    send(1'b1, 2, 1'b1);
    cfg_if.cfg_valid = 1'b0;
    wait_idle();

    // Reset while a ratio-8 change on channel 1 is pending
    wait_rise(0);
    send(1'b0, 8, 1'b1);
    cfg_if.cfg_valid = 1'b0;
    @(negedge clkin);
    check_eq("busy_in_wait", int'(cfg_if.busy), 1);
    #1 reset_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clkin);
    check_eq("rst_wait_clkout1", int'(clkout1), 0);
    check_eq("rst_wait_busy", int'(cfg_if.busy), 0);
    #1 reset_n = 1'b1;
    cur_half   = '{2, 5};
    cur_en     = '{1'b1, 1'b1};
    last_apply = 0;
    @(negedge clkin);
    check_eq("ready_after_wait_rst", int'(cfg_if.cfg_ready), 1);
    phases(0, h, l);
    check_eq("post_rst_high_ch1", h, 2);
    check_eq("post_rst_low_ch1", l, 2);
    phases(1, h, l);
    check_eq("post_rst_high_ch2", h, 5);
    check_eq("post_rst_low_ch2", l, 5);

    // Back-to-back requests with cfg_valid held high
    send(1'b0, 6, 1'b1);
    send(1'b1, 4, 1'b1);
    cfg_if.cfg_valid = 1'b0;
    wait_idle();

    check_eq("sb_empty", sb.size(), 0);
    check_eq("apply_count", n_apply, 5);
    check_eq("reject_count", n_rej, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Runtime controller for the two divided clocks in the clock-generation top level. It owns the divide counters for `clkout1` and `clkout2` and accepts reconfiguration requests over a valid/ready port. Each request changes a channel's divide ratio or enable. Every change is applied only at the channel's low-to-high boundary, so a divided clock never shows a runt pulse or a truncated high phase.

## Interface
- `CNT_WIDTH`, 8: width of divide ratio and counters.
- `DIV1_INIT`, 4: reset divide ratio of channel 1, in `clkin` cycles per output period. Must be even, ≥2.
- `DIV2_INIT`, 10: reset divide ratio of channel 2. Same rules as `DIV1_INIT`.
- `clkin`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  request valid.
- `cfg_ready`  out  1  controller can accept a request (IDLE).
- `cfg_sel`  in  1  target channel: 0 = `clkout1`, 1 = `clkout2`.
- `cfg_div`  in  CNT_WIDTH  new full-period divide ratio.
- `cfg_en`  in  1  new channel enable.
- `busy`  out  1  request accepted, not yet applied (= `!cfg_ready`).
- `err`  out  1  one-cycle pulse: request rejected.
- `clkout1`  out  1  divided clock, channel 1.
- `clkout2`  out  1  divided clock, channel 2.

## Operation
- **Per channel state:** `half` (ratio/2), counter `cnt`, `en`, output register `clkout`.
- **Enabled channel:**
  - `cnt` counts 0..`half`-1.
  - When `cnt==half-1`: `cnt` goes to 0 and `clkout` toggles.
  - Output period = ratio cycles, 50% duty.
- **Disabled channel:** `clkout` held 0, `cnt` held 0.
- **Handshake:** a transfer occurs on the edge where `cfg_valid && cfg_ready`. Request fields are captured at that edge and need not be held afterwards.
- **Validation at transfer:** if `cfg_en=1` and `cfg_div` is odd or <2, the request is rejected.
  - `err`=1 for the next cycle.
  - No state changes; FSM stays in IDLE.
  - If `cfg_en=0`, `cfg_div` is ignored and always accepted.
- **FSM states:**
  - **IDLE:** `cfg_ready`=1. A valid transfer goes to WAIT. An invalid transfer stays in IDLE.
  - **WAIT:** `cfg_ready`=0. Watches the target channel for its apply condition:
    - Enabled target: the edge where `clkout`=0 and `cnt==half-1`, i.e. the edge that would produce a rising output.
    - Disabled target: the first edge in WAIT.
  - **Apply edge (WAIT to IDLE):** target `half` ← `cfg_div/2` (if `cfg_en`); `cnt` ← 0; `clkout` ← captured `cfg_en`; `en` ← captured `cfg_en`.
- **Untargeted channel:** runs undisturbed throughout.
- **Request during WAIT:** ignored, because `cfg_ready`=0. No queueing.
- **Re-applying current settings:** handled the same way; the output is undisturbed.

## Timing
- **Reset values** (asynchronous, immediate on `reset_n`=0):
  - `clkout1`=0, `clkout2`=0.
  - `cfg_ready`=1 once `reset_n`=1; `busy`=0, `err`=0.
  - FSM in IDLE, counters 0, ratios `DIV1_INIT`/`DIV2_INIT`, both channels enabled.
- **After reset release:** `clkout1` first rises on the `DIV1_INIT/2`-th `clkin` rising edge.
- **Handshake latency:**
  - `cfg_ready` drops the cycle after transfer.
  - `err` asserts the cycle after transfer and lasts one cycle.
- **Apply latency:**
  - Enabled target: 1 to ratio_old cycles after transfer.
  - Disabled target: exactly 1 cycle after transfer.
  - `cfg_ready` returns high on the cycle after the apply edge.
- **New ratio takes effect** on the high phase that starts at the apply edge. The old low phase always completes in full.
- **Disable:** the output falls at its normal falling edge, and the apply edge then holds it low. No high phase is shortened.
- **`reset_n` asserted in WAIT:** the pending request is discarded and everything returns to the reset values.

## Test plan
- **Reset defaults:** reset released at t=40 ns, `clkin` period 20 ns, defaults.
  - `clkout1` period 80 ns, `clkout2` period 200 ns, both 50% duty.
  - First `clkout1` rise on the 2nd `clkin` edge after release.
- **Reconfigure channel 1:** `cfg_sel`=0, `cfg_div`=6, `cfg_en`=1 issued mid high phase.
  - `busy` held until the next `clkout1` rise.
  - From that rise, high=3 and low=3 cycles.
  - `clkout2` unchanged throughout.
- **Odd ratio rejected:** `cfg_div`=5, `cfg_en`=1.
  - One-cycle `err` pulse; `cfg_ready` stays 1; both periods unchanged.
- **Disable then re-enable channel 2:** disable with `cfg_en`=0.
  - `clkout2` completes its current high phase, then stays 0.
  - Re-enable with `cfg_div`=2: `clkout2` rises 1 cycle after transfer, then toggles every cycle.
- **Reset during WAIT:** `reset_n`=0 during WAIT for a ratio-8 change on channel 1.
  - After release, `clkout1` period is 80 ns, not 160 ns.
  - `cfg_ready`=1.
- **Back-to-back requests:** `cfg_valid` held high with two different requests.
  - The second transfers only after the first is applied.
  - No request is lost or duplicated.
